// File: rtl/hpu_pkg.sv
// Shared types and constants for the dcache refill controller.
// Contents: the refill FSM state encoding, the refill watchdog limit and its width.
package hpu_pkg;

  typedef enum logic [2:0] {
    RFL_IDLE,
    RFL_WB,
    RFL_RF_REQ,
    RFL_RF_DATA,
    RFL_DONE
  } dcache_rfl_state_e;

  // RF_DATA cycles without a beat before the refill is abandoned
  localparam int unsigned RFL_TIMEOUT = 255;
  localparam int unsigned RFL_WDOG_W  = 8;

endpackage : hpu_pkg

// File: rtl/dcache_rfl_beat_cnt.sv
// Line beat counter shared by the write-back and refill phases.
// Ports:
//   clk_i, rst_i : clock, async active-low reset
//   inc_i        : advance one beat (wraps naturally after the last beat)
//   clr_i        : force the count back to beat 0 (abandoned refill)
//   cnt_o        : current beat number (registered)
//   last_c       : current beat is the final beat of the line (combinational)
module dcache_rfl_beat_cnt #(
  parameter int unsigned LINE_BEATS = 4,
  parameter int unsigned BEAT_SEL   = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                inc_i,
  input  logic                clr_i,
  output logic [BEAT_SEL-1:0] cnt_o,
  output logic                last_c
);

  logic [BEAT_SEL-1:0] cnt_q;

  // Beat count register; clear has priority over increment
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + BEAT_SEL'(1);
    end
  end

  assign cnt_o  = cnt_q;
  assign last_c = (cnt_q == BEAT_SEL'(LINE_BEATS - 1));

endmodule : dcache_rfl_beat_cnt

// File: rtl/dcache_refill_ctrl.sv
// L1 dcache miss sequencer: one miss in flight. Picks the victim way from the
// pseudo-LRU table, writes the victim back to L2 when dirty, refills the line
// from L2, installs it beat by beat and finally marks the new line MRU.
// Ports:
//   clk_i, rst_i                  : clock, async active-low reset
//   miss_req_i/entry/tag, ack     : miss handshake; ack pulses when latched
//   miss_done_o, busy_o           : line installed pulse, controller occupied
//   rpl_l1d_entry_o, hot_l1d_onehot_i, victim_dirty_i : victim lookup
//   fill_hit_o, fill_entry_o      : one-cycle MRU update for the new line
//   wb_*                          : write-back beat channel to L2
//   rf_req_o/tag/gnt, rf_vld_i    : refill request and data beats from L2
//   l1_wr_*, l1_tag_wr_o          : L1 data/tag write port
//   err_o                         : refill abandoned (only with
//                                   DCACHE_REFILL_TIMEOUT_EN defined)
// Optional build macro: DCACHE_REFILL_TIMEOUT_EN adds an RF_DATA watchdog.
module dcache_refill_ctrl
  import hpu_pkg::*;
#(
  parameter int unsigned ENTRY_SEL  = 7,
  parameter int unsigned L1_WAYS    = 2,
  parameter int unsigned TAG_WT     = 20,
  parameter int unsigned LINE_BEATS = 4,
  parameter int unsigned BEAT_SEL   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
`ifdef DCACHE_REFILL_TIMEOUT_EN
  output logic                 err_o,
`endif
  input  logic                 miss_req_i,
  input  logic [ENTRY_SEL-1:0] miss_entry_i,
  input  logic [TAG_WT-1:0]    miss_tag_i,
  output logic                 miss_ack_o,
  output logic                 miss_done_o,
  output logic                 busy_o,
  output logic [ENTRY_SEL-1:0] rpl_l1d_entry_o,
  input  logic [L1_WAYS-1:0]   hot_l1d_onehot_i,
  input  logic [L1_WAYS-1:0]   victim_dirty_i,
  output logic [L1_WAYS-1:0]   fill_hit_o,
  output logic [ENTRY_SEL-1:0] fill_entry_o,
  output logic                 wb_vld_o,
  input  logic                 wb_ready_i,
  output logic [BEAT_SEL-1:0]  wb_beat_o,
  output logic                 wb_last_o,
  output logic                 rf_req_o,
  output logic [TAG_WT-1:0]    rf_tag_o,
  input  logic                 rf_gnt_i,
  input  logic                 rf_vld_i,
  output logic                 l1_wr_en_o,
  output logic [L1_WAYS-1:0]   l1_wr_way_o,
  output logic [ENTRY_SEL-1:0] l1_wr_entry_o,
  output logic [BEAT_SEL-1:0]  l1_wr_beat_o,
  output logic                 l1_tag_wr_o
);

  dcache_rfl_state_e    state_q, state_d;
  logic [ENTRY_SEL-1:0] entry_q;
  logic [TAG_WT-1:0]    tag_q;
  logic [L1_WAYS-1:0]   way_q;
  logic                 capture;
  logic                 cnt_inc;
  logic                 cnt_clr;
  logic [BEAT_SEL-1:0]  cnt;
  logic                 cnt_last;

`ifdef DCACHE_REFILL_TIMEOUT_EN
  logic [RFL_WDOG_W-1:0] wdog_q, wdog_d;
  logic                  timeout_c;
`endif

  // One beat counter serves both WB and RF_DATA; it is back at 0 between them
  dcache_rfl_beat_cnt #(
    .LINE_BEATS (LINE_BEATS),
    .BEAT_SEL   (BEAT_SEL)
  ) u_beat_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (cnt_inc),
    .clr_i  (cnt_clr),
    .cnt_o  (cnt),
    .last_c (cnt_last)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RFL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Miss context captured on the accept cycle
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      entry_q <= '0;
      tag_q   <= '0;
      way_q   <= '0;
    end else if (capture) begin
      entry_q <= miss_entry_i;
      tag_q   <= miss_tag_i;
      way_q   <= hot_l1d_onehot_i;
    end
  end

`ifdef DCACHE_REFILL_TIMEOUT_EN
  // Refill watchdog: counts consecutive beat-less RF_DATA cycles
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end

  // Current cycle is the RFL_TIMEOUT-th beat-less cycle
  assign timeout_c = (wdog_q == RFL_WDOG_W'(RFL_TIMEOUT - 1));
`endif

  // Next-state and output decode
  always_comb begin
    state_d         = state_q;
    capture         = 1'b0;
    cnt_inc         = 1'b0;
    cnt_clr         = 1'b0;
    miss_ack_o      = 1'b0;
    miss_done_o     = 1'b0;
    busy_o          = (state_q != RFL_IDLE);
    rpl_l1d_entry_o = '0;
    fill_hit_o      = '0;
    fill_entry_o    = '0;
    wb_vld_o        = 1'b0;
    wb_beat_o       = '0;
    wb_last_o       = 1'b0;
    rf_req_o        = 1'b0;
    rf_tag_o        = '0;
    l1_wr_en_o      = 1'b0;
    l1_wr_way_o     = '0;
    l1_wr_entry_o   = '0;
    l1_wr_beat_o    = '0;
    l1_tag_wr_o     = 1'b0;
`ifdef DCACHE_REFILL_TIMEOUT_EN
    err_o           = 1'b0;
    wdog_d          = '0;
`endif

    unique case (state_q)
      RFL_IDLE: begin
        // LRU table answers combinationally for the requested set
        rpl_l1d_entry_o = miss_entry_i;
        if (miss_req_i) begin
          miss_ack_o = 1'b1;
          capture    = 1'b1;
          state_d    = (|(victim_dirty_i & hot_l1d_onehot_i)) ? RFL_WB : RFL_RF_REQ;
        end
      end

      RFL_WB: begin
        wb_vld_o  = 1'b1;
        wb_beat_o = cnt;
        wb_last_o = cnt_last;
        if (wb_ready_i) begin
          cnt_inc = 1'b1;
          if (cnt_last) begin
            state_d = RFL_RF_REQ;
          end
        end
      end

      RFL_RF_REQ: begin
        // Early data beats are not expected here and are dropped
        rf_req_o = 1'b1;
        rf_tag_o = tag_q;
        if (rf_gnt_i) begin
          state_d = RFL_RF_DATA;
        end
      end

      RFL_RF_DATA: begin
        if (rf_vld_i) begin
          l1_wr_en_o    = 1'b1;
          l1_wr_way_o   = way_q;
          l1_wr_entry_o = entry_q;
          l1_wr_beat_o  = cnt;
          cnt_inc       = 1'b1;
          if (cnt_last) begin
            // Tag written last so a partial line never becomes valid
            l1_tag_wr_o = 1'b1;
            state_d     = RFL_DONE;
          end
        end
`ifdef DCACHE_REFILL_TIMEOUT_EN
        else if (timeout_c) begin
          err_o   = 1'b1;
          cnt_clr = 1'b1;
          state_d = RFL_IDLE;
        end else begin
          wdog_d = wdog_q + RFL_WDOG_W'(1);
        end
`endif
      end

      RFL_DONE: begin
        miss_done_o  = 1'b1;
        fill_hit_o   = way_q;
        fill_entry_o = entry_q;
        state_d      = RFL_IDLE;
      end

      default: begin
        state_d = RFL_IDLE;
      end
    endcase
  end

endmodule : dcache_refill_ctrl
